// File: rtl/cone_bist_sequencer.sv
// cone_bist_sequencer
// Built-in self-test sequencer for one combinational output cone. An LFSR
// generates the input vectors, each vector is held for a settle time, the
// cone output is then sampled and folded into a serial signature register,
// and the final signature is compared with a golden value.
module cone_bist_sequencer #(
    parameter int              NIN    = 13,
    parameter int              NPAT   = 1024,
    parameter int              SETTLE = 2,
    parameter logic [NIN-1:0]  SEED   = 13'h0001,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             cone_out,
    output logic [NIN-1:0]   cone_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [NIN-1:0] SEED_EFF =
        (SEED == {NIN{1'b0}}) ? {{(NIN-1){1'b0}}, 1'b1} : SEED;

    // Settle counter runs 0..SETTLE-1.
    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(SETTLE - 1);
    localparam logic [15:0]    PAT_LAST  = 16'(NPAT - 1);

    // Next LFSR state; taps are fixed for a 13-bit register.
    function automatic logic [NIN-1:0] lfsr_next(input logic [NIN-1:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    // Serial signature update with polynomial 0x1021.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic d);
        logic fb;
        fb = s[SIG_W-1] ^ d;
        return {s[SIG_W-2:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [1:0]       state_r, state_s;
    logic [NIN-1:0]   lfsr_r, lfsr_s;
    logic [SIG_W-1:0] sig_r, sig_s;
    logic [15:0]      pat_r, pat_s;
    logic [WCW-1:0]   wcnt_r, wcnt_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic             busy_r, busy_s;
    logic [NIN-1:0]   cone_in_r, cone_in_s;

    // Next-state and datapath update; abort overrides everything else.
    always_comb begin
        state_s = state_r;
        lfsr_s  = lfsr_r;
        sig_s   = sig_r;
        pat_s   = pat_r;
        wcnt_s  = wcnt_r;
        done_s  = done_r;
        pass_s  = pass_r;
        if (abort) begin
            state_s = ST_IDLE;
            done_s  = 1'b0;
            pass_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        state_s = ST_WAIT;
                        lfsr_s  = SEED_EFF;
                        sig_s   = {SIG_W{1'b0}};
                        pat_s   = 16'd0;
                        wcnt_s  = {WCW{1'b0}};
                        done_s  = 1'b0;
                        pass_s  = 1'b0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_WAIT: begin
                    wcnt_s = wcnt_r + WCW'(1);
                    if (wcnt_r == WCNT_LAST) begin
                        state_s = ST_CAPT;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_CAPT: begin
                    sig_s = misr_next(sig_r, cone_out);
                    pat_s = pat_r + 16'd1;
                    if (pat_r == PAT_LAST) begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                        pass_s  = (sig_s == GOLDEN);
                    end else begin
                        state_s = ST_WAIT;
                        lfsr_s  = lfsr_next(lfsr_r);
                        wcnt_s  = {WCW{1'b0}};
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        busy_s    = (state_s == ST_WAIT) || (state_s == ST_CAPT);
        cone_in_s = busy_s ? lfsr_s : {NIN{1'b0}};
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= {NIN{1'b0}};
            sig_r     <= {SIG_W{1'b0}};
            pat_r     <= 16'd0;
            wcnt_r    <= {WCW{1'b0}};
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            busy_r    <= 1'b0;
            cone_in_r <= {NIN{1'b0}};
        end else begin
            state_r   <= state_s;
            lfsr_r    <= lfsr_s;
            sig_r     <= sig_s;
            pat_r     <= pat_s;
            wcnt_r    <= wcnt_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            busy_r    <= busy_s;
            cone_in_r <= cone_in_s;
        end
    end

    assign cone_in   = cone_in_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_r;
    assign pat_cnt   = pat_r;

endmodule

// File: tb/tb_cone_bist_sequencer.sv
// Testbench for cone_bist_sequencer: directed runs from the documented
// examples plus randomized cone functions checked against a reference model.
module tb_cone_bist_sequencer;

    localparam int NP  = 4;
    localparam int ST  = 2;
    localparam int PER = ST + 1;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cone_out;
    logic        tie_mode = 1'b1;
    logic        tie_val = 1'b1;
    logic [12:0] mask = 13'h0;

    logic [12:0] cone_in, cone_in_z;
    logic        busy, done, pass, busy_z, done_z, pass_z;
    logic [15:0] signature, signature_z, pat_cnt, pat_cnt_z;

    int tests = 0;
    int fails = 0;

    logic [12:0] vec_q [NP];
    logic [15:0] sig_q [NP+1];

    cone_bist_sequencer #(.NIN(13), .NPAT(NP), .SETTLE(ST), .SEED(13'h0001),
                          .SIG_W(16), .GOLDEN(16'h0000)) dut (
        .CK(CK), .RST(RST), .start(start), .abort(abort), .cone_out(cone_out),
        .cone_in(cone_in), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pat_cnt(pat_cnt));

    cone_bist_sequencer #(.NIN(13), .NPAT(NP), .SETTLE(ST), .SEED(13'h0000),
                          .SIG_W(16), .GOLDEN(16'h0000)) dut0 (
        .CK(CK), .RST(RST), .start(start), .abort(abort), .cone_out(cone_out),
        .cone_in(cone_in_z), .busy(busy_z), .done(done_z), .pass(pass_z),
        .signature(signature_z), .pat_cnt(pat_cnt_z));

    always #5 CK = ~CK;

    // Emulated cone: either a constant or the parity of a masked input subset.
    assign cone_out = tie_mode ? tie_val : ^(cone_in & mask);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Reference: vector k is the seed advanced k times; the signature is the
    // running polynomial fold of each pattern's response bit.
    task automatic build_model();
        logic [12:0] v;
        logic [15:0] s;
        logic        b;
        v = 13'h0001;
        for (int k = 0; k < NP; k++) begin
            vec_q[k] = v;
            v = {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
        end
        s = 16'h0000;
        sig_q[0] = s;
        for (int k = 0; k < NP; k++) begin
            b = tie_mode ? tie_val : ^(vec_q[k] & mask);
            s = (s[15] ^ b) ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
            sig_q[k+1] = s;
        end
    endtask

    // One full run from a start pulse, checking every cycle until FIN.
    task automatic run_full(input bit noise);
        int k;
        start = 1'b1;
        abort = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < NP * PER; c++) begin
            k = c / PER;
            check("run_cone_in", cone_in, vec_q[k]);
            check("run_seed0_cone_in", cone_in_z, vec_q[k]);
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            check("run_pass", pass, 1'b0);
            check("run_pat_cnt", pat_cnt, k);
            check("run_signature", signature, sig_q[k]);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        check("fin_done", done, 1'b1);
        check("fin_busy", busy, 1'b0);
        check("fin_cone_in", cone_in, 13'h0000);
        check("fin_pat_cnt", pat_cnt, NP);
        check("fin_signature", signature, sig_q[NP]);
        check("fin_pass", pass, (sig_q[NP] == 16'h0000));
        check("fin_seed0_signature", signature_z, sig_q[NP]);
        tick();
        check("fin_hold_done", done, 1'b1);
        check("fin_hold_signature", signature, sig_q[NP]);
        check("fin_hold_pat_cnt", pat_cnt, NP);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_cone_in", cone_in, 13'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_signature", signature, 16'h0000);
        check("rst_pat_cnt", pat_cnt, 16'h0000);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // Documented sequence with cone_out tied high
        tie_mode = 1'b1;
        tie_val  = 1'b1;
        vec_q = '{13'h0001, 13'h0003, 13'h0007, 13'h000E};
        sig_q = '{16'h0000, 16'h1021, 16'h3063, 16'h70E7, 16'hF1EF};
        run_full(1'b0);
        check("tied1_final_sig", signature, 16'hF1EF);
        check("tied1_pass", pass, 1'b0);

        // Abort during the second pattern's settle time
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_pass", pass, 1'b0);
        check("abort_cone_in", cone_in, 13'h0000);
        check("abort_pat_cnt", pat_cnt, 16'd1);
        check("abort_signature", signature, 16'h1021);

        // start together with abort in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", busy, 1'b0);
        check("startabort_cone_in", cone_in, 13'h0000);
        check("startabort_pat_cnt", pat_cnt, 16'd1);
        tick();
        check("startabort_still_idle", busy, 1'b0);

        // Restart reproduces the full run
        build_model();
        run_full(1'b0);
        check("rerun_final_sig", signature, 16'hF1EF);

        // Golden match with cone_out tied low; also a restart from FIN
        tie_val = 1'b0;
        build_model();
        run_full(1'b1);
        check("golden_sig", signature, 16'h0000);
        check("golden_pass", pass, 1'b1);
        check("golden_pat_cnt", pat_cnt, 16'd4);

        // Random cone functions, random start pulses while busy
        tie_mode = 1'b0;
        for (int r = 0; r < 6; r++) begin
            mask = 13'($urandom);
            build_model();
            run_full(1'b1);
        end

        // Asynchronous reset while in CAPT of the second pattern
        tie_mode = 1'b1;
        tie_val  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("precapt_pat_cnt", pat_cnt, 16'd1);
        RST = 1'b1;
        #1;
        check("arst_cone_in", cone_in, 13'h0000);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_pass", pass, 1'b0);
        check("arst_signature", signature, 16'h0000);
        check("arst_pat_cnt", pat_cnt, 16'h0000);
        check("arst_seed0_cone_in", cone_in_z, 13'h0000);
        #2;
        RST = 1'b0;
        tick();
        check("postrst_idle", busy, 1'b0);

        // Post-reset run; the SEED=0 instance must start from 0001
        tie_mode = 1'b0;
        mask = 13'($urandom);
        build_model();
        run_full(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
